serial_adder_sub: RTL and testbench



---
 rtl/serial_adder_sub_if.sv | 42 ++++
 rtl/serial_adder_sub.sv | 130 +++++++++++++
 tb/tb_serial_adder_sub.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_sub_if
// Description : Request/result bundle for the bit-serial adder/subtractor.
//               The master drives start/mode/cin/a/b and observes
//               busy/done/sum/cout/ovf. The slave is the arithmetic unit.
//   start  request, sampled only when the unit is idle or signalling done
//   mode   0 = add, 1 = subtract (a - b)
//   cin    carry-in for add, ignored in subtract
//   a, b   operands (WIDTH bits)
//   busy   bits are being processed
//   done   one-cycle pulse, result valid
//   sum    result (WIDTH bits)
//   cout   carry out of MSB (subtract: 1 = no borrow)
//   ovf    signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, mode, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_sub
// Description : Bit-serial adder/subtractor. One full-adder cell and a carry
//               flop process one bit per clock, LSB first. A result is ready
//               WIDTH+1 edges after the start edge; back-to-back requests are
//               accepted during the done cycle.
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    serial_adder_sub_if slave modport (request, status and result)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    serial_adder_sub_if.slave      bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_s;
    logic             w_fa_co;
    logic             w_busy;
    logic             w_done;

    // A request is only honoured in IDLE or DONE; start during RUN is dropped.
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // The single full-adder cell.
    assign w_fa_s  = r_a[0] ^ r_b[0] ^ r_c;
    assign w_fa_co = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1: invert b on load and seed the carry.
            r_a   <= bus.a;
            r_b   <= bus.mode ? ~bus.b : bus.b;
            r_c   <= bus.mode ? 1'b1 : bus.cin;
            r_sum <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sum <= {w_fa_s, r_sum[WIDTH-1:1]};
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_c   <= w_fa_co;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                // r_c still holds the carry into the MSB at this point.
                r_cout <= w_fa_co;
                r_ovf  <= r_c ^ w_fa_co;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_sub
// Description : Self-checking bench for serial_adder_sub. Three instances
//               (WIDTH 8, 4, 16); a per-instance monitor pushes a reference
//               result whenever a request is accepted and pops/compares it
//               when done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_sub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_sub_if #(.WIDTH(8))  bus8  ();
    serial_adder_sub_if #(.WIDTH(4))  bus4  ();
    serial_adder_sub_if #(.WIDTH(16)) bus16 ();

    serial_adder_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_sub #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    serial_adder_sub #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, cout, sum[31:0]} for a w-bit operation.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic mode, input logic cin);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bb;
        logic [32:0] full;
        logic [31:0] s;
        logic        co;
        logic        ov;
        mask = 32'((64'd1 << w) - 64'd1);
        am   = a & mask;
        bb   = mode ? (~b & mask) : (b & mask);
        full = {1'b0, am} + {1'b0, bb} + {32'd0, (mode ? 1'b1 : cin)};
        s    = full[31:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    logic [33:0] q8[$];
    logic [33:0] q4[$];
    logic [33:0] q16[$];
    logic [33:0] e8, e4, e16;

    // Monitors: pop on done first, then push for a request accepted on the
    // coming edge (start with the unit not busy).
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
        end else begin
            if (bus8.done) begin
                if (q8.size() == 0) chk("dut8 done without request", 64'(q8.size()), 64'd1);
                else begin
                    e8 = q8.pop_front();
                    chk("dut8 result {ovf,cout,sum}", {30'd0, bus8.ovf, bus8.cout, 24'd0, bus8.sum}, {30'd0, e8});
                end
            end
            if (bus8.start && !bus8.busy)
                q8.push_back(model(8, 32'(bus8.a), 32'(bus8.b), bus8.mode, bus8.cin));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
        end else begin
            if (bus4.done) begin
                if (q4.size() == 0) chk("dut4 done without request", 64'(q4.size()), 64'd1);
                else begin
                    e4 = q4.pop_front();
                    chk("dut4 result {ovf,cout,sum}", {30'd0, bus4.ovf, bus4.cout, 28'd0, bus4.sum}, {30'd0, e4});
                end
            end
            if (bus4.start && !bus4.busy)
                q4.push_back(model(4, 32'(bus4.a), 32'(bus4.b), bus4.mode, bus4.cin));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q16.delete();
        end else begin
            if (bus16.done) begin
                if (q16.size() == 0) chk("dut16 done without request", 64'(q16.size()), 64'd1);
                else begin
                    e16 = q16.pop_front();
                    chk("dut16 result {ovf,cout,sum}", {30'd0, bus16.ovf, bus16.cout, 16'd0, bus16.sum}, {30'd0, e16});
                end
            end
            if (bus16.start && !bus16.busy)
                q16.push_back(model(16, 32'(bus16.a), 32'(bus16.b), bus16.mode, bus16.cin));
        end
    end

    // One WIDTH=8 operation from idle; called at posedge+1.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic mode, input logic cin,
                       input logic [7:0] xs, input logic xc, input logic xo);
        int n;
        bus8.a = a; bus8.b = b; bus8.mode = mode; bus8.cin = cin;
        bus8.start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (n == 0) bus8.start = 1'b0;
            n++;
        end while (!bus8.done && n < 40);
        chk({tag, " latency"}, 64'(n), 64'd9);
        chk({tag, " sum"},  64'(bus8.sum),  64'(xs));
        chk({tag, " cout"}, 64'(bus8.cout), 64'(xc));
        chk({tag, " ovf"},  64'(bus8.ovf),  64'(xo));
    endtask

    logic [7:0] bb_a [2];
    logic [7:0] bb_b [2];
    logic       bb_m [2];
    logic [7:0] bb_s [2];

    initial begin : main
        int n_done;
        int cyc;
        int last;
        int k;
        int acc;

        rst = 1'b1;
        bus8.start = 0;  bus8.mode = 0;  bus8.cin = 0;  bus8.a = '0;  bus8.b = '0;
        bus4.start = 0;  bus4.mode = 0;  bus4.cin = 0;  bus4.a = '0;  bus4.b = '0;
        bus16.start = 0; bus16.mode = 0; bus16.cin = 0; bus16.a = '0; bus16.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(bus8.busy), 64'd0);
        chk("reset done", 64'(bus8.done), 64'd0);
        chk("reset sum",  64'(bus8.sum),  64'd0);
        chk("reset cout", 64'(bus8.cout), 64'd0);
        chk("reset ovf",  64'(bus8.ovf),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed known answers (cin=1 in subtract must be ignored).
        op8("add 5A+3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        @(posedge clk); #1;
        op8("add FF+01+1", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
        @(posedge clk); #1;
        op8("sub 10-20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        @(posedge clk); #1;
        op8("sub 80-01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
        repeat (2) @(posedge clk); #1;

        // start pulsed with new operands during RUN must be ignored.
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.mode = 1'b0; bus8.cin = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 3) begin
                bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.mode = 1'b1; bus8.start = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            if (bus8.done) begin
                n_done++;
                chk("ignored start sum", 64'(bus8.sum), 64'h96);
            end
            @(posedge clk); #1;
        end
        chk("ignored start done count", 64'(n_done), 64'd1);

        // Reset mid-run after four bits.
        bus8.a = 8'h5A; bus8.b = 8'h3C; bus8.mode = 1'b0; bus8.cin = 1'b0;
        bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun rst busy", 64'(bus8.busy), 64'd0);
        chk("midrun rst done", 64'(bus8.done), 64'd0);
        chk("midrun rst sum",  64'(bus8.sum),  64'd0);
        chk("midrun rst cout", 64'(bus8.cout), 64'd0);
        chk("midrun rst ovf",  64'(bus8.ovf),  64'd0);
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done) n_done++;
            @(posedge clk); #1;
        end
        chk("midrun rst no done", 64'(n_done), 64'd0);
        op8("after rst 5A+3C", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Back-to-back with start held high and alternating vectors.
        bb_a[0] = 8'h5A; bb_b[0] = 8'h3C; bb_m[0] = 1'b0; bb_s[0] = 8'h96;
        bb_a[1] = 8'h80; bb_b[1] = 8'h01; bb_m[1] = 1'b1; bb_s[1] = 8'h7F;
        bus8.a = bb_a[0]; bus8.b = bb_b[0]; bus8.mode = bb_m[0]; bus8.cin = 1'b0;
        bus8.start = 1'b1;
        cyc = 0; last = 0; k = 0;
        while (k < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            chk("b2b busy xor done", 64'(bus8.busy ^ bus8.done), 64'd1);
            if (bus8.done) begin
                chk("b2b sum", 64'(bus8.sum), 64'(bb_s[k % 2]));
                if (k > 0) chk("b2b done period", 64'(cyc - last), 64'd9);
                last = cyc;
                k++;
                if (k == 4) bus8.start = 1'b0;
                else begin
                    bus8.a = bb_a[k % 2]; bus8.b = bb_b[k % 2]; bus8.mode = bb_m[k % 2];
                end
            end
        end
        bus8.start = 1'b0;
        chk("b2b results seen", 64'(k), 64'd4);
        repeat (3) @(posedge clk); #1;

        // Random WIDTH=4; inputs change every cycle, also while busy.
        acc = 0; cyc = 0;
        while (acc < 200 && cyc < 5000) begin
            bus4.start = (($urandom % 4) != 0);
            bus4.mode  = 1'($urandom);
            bus4.cin   = 1'($urandom);
            bus4.a     = 4'($urandom);
            bus4.b     = 4'($urandom);
            if (bus4.start && !bus4.busy) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        bus4.start = 1'b0;
        for (int i = 0; i < 40 && q4.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("dut4 accepted ops", 64'(acc), 64'd200);
        chk("dut4 queue drained", 64'(q4.size()), 64'd0);

        // Random WIDTH=16.
        acc = 0; cyc = 0;
        while (acc < 200 && cyc < 12000) begin
            bus16.start = (($urandom % 4) != 0);
            bus16.mode  = 1'($urandom);
            bus16.cin   = 1'($urandom);
            bus16.a     = 16'($urandom);
            bus16.b     = 16'($urandom);
            if (bus16.start && !bus16.busy) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        bus16.start = 1'b0;
        for (int i = 0; i < 60 && q16.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("dut16 accepted ops", 64'(acc), 64'd200);
        chk("dut16 queue drained", 64'(q16.size()), 64'd0);
        chk("dut8 queue drained", 64'(q8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
